uart_mem_streamer: RTL and testbench

Command-driven bridge between the UART receiver/transmitter pair and a synchronous-read memory. Byte commands arriving on the RX strobe interface start block reads. Each word read from memory is serialised MSB byte first onto the TX interface, paced by `busy`/`block`. This block is the parametrised successor of the fixed 8-bit data controller. It adds wider memory words, a wider address, a byte count per command, a full dump, abort, and command timeout.

---
 rtl/uart_mem_streamer.sv | 158 +++++++++++++++
 tb/tb_uart_mem_streamer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_streamer.sv
// Command-driven bridge: RX byte commands start block reads from a synchronous-read
// memory; each word is sent MSB byte first on the TX strobe interface.
module uart_mem_streamer #(
  parameter int ADDR_W      = 8,
  parameter int BPW         = 1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 busy,
  input  logic                 block,
  output logic                 new_data_tx,
  output logic [7:0]           data_tx,
  input  logic                 new_data_rx,
  input  logic [7:0]           data_rx,
  input  logic [8*BPW-1:0]     data,
  output logic [ADDR_W-1:0]    addr,
  output logic                 active
);

  localparam int AB     = (ADDR_W <= 8) ? 1 : 2;
  localparam int DATA_W = 8 * BPW;
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_CNT, RD_WAIT, LOAD, SEND, GAP, REPLY
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   word;
  logic [1:0]          idx;
  logic [16:0]         wcnt;
  logic                abort_f;
  logic [7:0]          last_tx;
  logic [7:0]          reply;
  logic                ab_cnt;
  logic [8*AB-1:0]     addr_sh;
  logic [TW-1:0]       tmo;
  logic [7:0]          cur_byte;
  logic                tx_ok;

  // The strobe is qualified in the issuing cycle so the first byte lands 3 cycles
  // after the count byte; data_tx otherwise shows the last byte sent.
  always_comb begin
    cur_byte    = 8'(word >> {idx, 3'b000});
    tx_ok       = !busy && !block;
    new_data_tx = tx_ok && ((state == SEND && !abort_f) || state == REPLY);
    data_tx     = last_tx;
    if (new_data_tx) data_tx = (state == REPLY) ? reply : cur_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      idx     <= '0;
      wcnt    <= '0;
      abort_f <= 1'b0;
      last_tx <= 8'h00;
      reply   <= 8'h00;
      ab_cnt  <= 1'b0;
      addr_sh <= '0;
      tmo     <= '0;
      addr    <= '0;
      active  <= 1'b0;
    end else begin
      if (state == IDLE)
        abort_f <= 1'b0;
      else if (active && new_data_rx && data_rx == 8'h1B)
        abort_f <= 1'b1;

      case (state)
        IDLE: if (new_data_rx) begin
          case (data_rx)
            8'h52: begin
              state  <= GET_ADDR;
              ab_cnt <= 1'b0;
              tmo    <= '0;
            end
            8'h44: begin
              addr   <= '0;
              wcnt   <= 17'd1 << ADDR_W;
              active <= 1'b1;
              state  <= RD_WAIT;
            end
            8'h3F: begin
              reply <= {4'hA, 4'(ADDR_W - 1)};
              state <= REPLY;
            end
            default: begin
              reply <= 8'h15;
              state <= REPLY;
            end
          endcase
        end
        GET_ADDR: begin
          if (new_data_rx) begin
            addr_sh <= (8*AB)'({addr_sh, data_rx});
            tmo     <= '0;
            if (ab_cnt == 1'(AB - 1)) state <= GET_CNT;
            else ab_cnt <= ab_cnt + 1'b1;
          end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        GET_CNT: begin
          if (new_data_rx) begin
            addr   <= ADDR_W'(addr_sh);
            wcnt   <= (data_rx == 8'h00) ? 17'd256 : {9'd0, data_rx};
            active <= 1'b1;
            state  <= RD_WAIT;
          end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RD_WAIT: state <= LOAD;
        LOAD: begin
          word  <= data;
          idx   <= 2'(BPW - 1);
          state <= SEND;
        end
        SEND: begin
          if (abort_f) begin
            active <= 1'b0;
            state  <= IDLE;
          end else if (tx_ok) begin
            last_tx <= cur_byte;
            state   <= GAP;
          end
        end
        GAP: begin
          if (idx != 2'd0) begin
            idx   <= idx - 1'b1;
            state <= SEND;
          end else if (wcnt == 17'd1) begin
            wcnt   <= '0;
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            wcnt  <= wcnt - 1'b1;
            addr  <= addr + 1'b1;
            state <= RD_WAIT;
          end
        end
        REPLY: if (tx_ok) begin
          last_tx <= reply;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_streamer.sv
// Directed bench for uart_mem_streamer: three instances cover the 8-bit/1-byte,
// 12-bit/2-byte and 4-bit dump configurations.
module tb_uart_mem_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a: ADDR_W=8, BPW=1, short timeout; memory data = ~addr
  logic       busy_a = 0, block_a = 0, ntx_a, nrx_a = 0, active_a;
  logic [7:0] dtx_a, drx_a = 0, data_a, addr_a;
  // instance b: ADDR_W=12, BPW=2; memory data = {addr[11:4], addr[7:0]}
  logic        busy_b = 0, block_b = 0, ntx_b, nrx_b = 0, active_b;
  logic [7:0]  dtx_b, drx_b = 0;
  logic [15:0] data_b;
  logic [11:0] addr_b;
  // instance c: ADDR_W=4, BPW=1; memory data = {4'h5, addr}
  logic       busy_c = 0, block_c = 0, ntx_c, nrx_c = 0, active_c;
  logic [7:0] dtx_c, drx_c = 0, data_c;
  logic [3:0] addr_c;

  uart_mem_streamer #(.ADDR_W(8), .BPW(1), .TIMEOUT_CYC(100)) u_a (
    .clk(clk), .rst(rst), .busy(busy_a), .block(block_a), .new_data_tx(ntx_a),
    .data_tx(dtx_a), .new_data_rx(nrx_a), .data_rx(drx_a), .data(data_a),
    .addr(addr_a), .active(active_a));
  uart_mem_streamer #(.ADDR_W(12), .BPW(2), .TIMEOUT_CYC(100)) u_b (
    .clk(clk), .rst(rst), .busy(busy_b), .block(block_b), .new_data_tx(ntx_b),
    .data_tx(dtx_b), .new_data_rx(nrx_b), .data_rx(drx_b), .data(data_b),
    .addr(addr_b), .active(active_b));
  uart_mem_streamer #(.ADDR_W(4), .BPW(1), .TIMEOUT_CYC(100)) u_c (
    .clk(clk), .rst(rst), .busy(busy_c), .block(block_c), .new_data_tx(ntx_c),
    .data_tx(dtx_c), .new_data_rx(nrx_c), .data_rx(drx_c), .data(data_c),
    .addr(addr_c), .active(active_c));

  always @(posedge clk) begin
    data_a <= ~addr_a;
    data_b <= {addr_b[11:4], addr_b[7:0]};
    data_c <= {4'h5, addr_c};
  end

  logic [7:0] tx_a[$], tx_b[$], tx_c[$];
  int         cyc_a[$], cyc_b[$], cyc_c[$];
  logic       prev_a = 0, prev_b = 0, prev_c = 0;
  int         consec = 0;

  always @(negedge clk) begin
    if (ntx_a) begin tx_a.push_back(dtx_a); cyc_a.push_back(cyc); end
    if (ntx_b) begin tx_b.push_back(dtx_b); cyc_b.push_back(cyc); end
    if (ntx_c) begin tx_c.push_back(dtx_c); cyc_c.push_back(cyc); end
    if ((ntx_a && prev_a) || (ntx_b && prev_b) || (ntx_c && prev_c)) consec++;
    prev_a = ntx_a; prev_b = ntx_b; prev_c = ntx_c;
  end

  task automatic clear_q();
    tx_a.delete(); tx_b.delete(); tx_c.delete();
    cyc_a.delete(); cyc_b.delete(); cyc_c.delete();
  endtask

  // Drives one rx strobe on instance d; t is the cycle the strobe occupies.
  task automatic send(input int d, input logic [7:0] b, output int t);
    @(posedge clk); #1;
    t = cyc;
    case (d)
      0: begin nrx_a = 1; drx_a = b; end
      1: begin nrx_b = 1; drx_b = b; end
      default: begin nrx_c = 1; drx_c = b; end
    endcase
    @(posedge clk); #1;
    nrx_a = 0; nrx_b = 0; nrx_c = 0;
  endtask

  task automatic wait_inactive(input int d, input int budget, output bit expired);
    logic act;
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      act = (d == 0) ? active_a : (d == 1) ? active_b : active_c;
      if (!act) begin expired = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_txcount(input int d, input int n, input int budget, output bit expired);
    int sz;
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      sz = (d == 0) ? tx_a.size() : (d == 1) ? tx_b.size() : tx_c.size();
      if (sz >= n) begin expired = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int t;
    bit ex;
    logic [7:0] exp3[3];
    exp3[0] = 8'hEF; exp3[1] = 8'hEE; exp3[2] = 8'hED;
    tests_run++;
    if ({ntx_a, dtx_a, addr_a, active_a} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_initial: tx=%0b data_tx=%h addr=%h active=%0b, want all zero",
               ntx_a, dtx_a, addr_a, active_a);
    end
    @(posedge clk); #1; rst = 0;
    send(0, 8'h52, t); send(0, 8'h10, t); send(0, 8'h05, t);
    wait_txcount(0, 2, 50, ex);
    tests_run++;
    if (ex) begin tests_failed++; $display("FAIL reset_prestream: no strobes before reset"); end
    @(posedge clk); #3; rst = 1; #1;
    tests_run++;
    if ({ntx_a, dtx_a, addr_a, active_a} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_async: tx=%0b data_tx=%h addr=%h active=%0b, want all zero",
               ntx_a, dtx_a, addr_a, active_a);
    end
    @(posedge clk); #1; rst = 0;
    clear_q();
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (tx_a.size() !== 0 || active_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_quiet: %0d strobes active=%0b after reset, want 0/0", tx_a.size(), active_a);
    end
    send(0, 8'h52, t); send(0, 8'h10, t); send(0, 8'h03, t);
    wait_inactive(0, 100, ex);
    tests_run++;
    if (ex || tx_a.size() !== 3) begin
      tests_failed++;
      $display("FAIL reset_restream: %0d bytes expired=%0b, want 3", tx_a.size(), ex);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (tx_a[i] !== exp3[i]) begin
          tests_failed++;
          $display("FAIL reset_restream_byte%0d: got %h want %h", i, tx_a[i], exp3[i]);
        end
      end
    end
  endtask

  task automatic test_read();
    int t;
    bit ex;
    clear_q();
    send(0, 8'h52, t); send(0, 8'h10, t); send(0, 8'h03, t);
    @(negedge clk);
    tests_run++;
    if (active_a !== 1'b1) begin
      tests_failed++; $display("FAIL read_active_rise: active=%0b want 1", active_a);
    end
    tests_run++;
    if (addr_a !== 8'h10) begin
      tests_failed++; $display("FAIL read_addr: addr=%h want 10", addr_a);
    end
    @(posedge clk); #1;
    wait_inactive(0, 100, ex);
    tests_run++;
    if (ex || tx_a.size() !== 3) begin
      tests_failed++; $display("FAIL read_count: %0d bytes expired=%0b want 3", tx_a.size(), ex);
    end else begin
      tests_run++;
      if ({tx_a[0], tx_a[1], tx_a[2]} !== 24'hEFEEED) begin
        tests_failed++;
        $display("FAIL read_bytes: got %h %h %h want ef ee ed", tx_a[0], tx_a[1], tx_a[2]);
      end
      tests_run++;
      if (cyc_a[0] !== t + 3) begin
        tests_failed++; $display("FAIL read_latency: first at %0d want %0d", cyc_a[0], t + 3);
      end
      tests_run++;
      if (cyc_a[1] - cyc_a[0] !== 4) begin
        tests_failed++; $display("FAIL read_word_gap: %0d want 4", cyc_a[1] - cyc_a[0]);
      end
    end
  endtask

  task automatic test_wrap_stall();
    int t;
    int rel;
    bit ex;
    clear_q();
    send(0, 8'h52, t); send(0, 8'hFE, t); send(0, 8'h03, t);
    wait_txcount(0, 1, 20, ex);
    block_a = 1;
    repeat (50) @(posedge clk);
    #1;
    tests_run++;
    if (ex || tx_a.size() !== 1 || addr_a !== 8'hFF) begin
      tests_failed++;
      $display("FAIL stall_hold: %0d bytes addr=%h want 1 byte addr ff", tx_a.size(), addr_a);
    end
    rel = cyc;
    block_a = 0;
    wait_inactive(0, 100, ex);
    tests_run++;
    if (ex || tx_a.size() !== 3) begin
      tests_failed++; $display("FAIL wrap_count: %0d bytes expired=%0b want 3", tx_a.size(), ex);
    end else begin
      tests_run++;
      if ({tx_a[0], tx_a[1], tx_a[2]} !== 24'h0100FF) begin
        tests_failed++;
        $display("FAIL wrap_bytes: got %h %h %h want 01 00 ff", tx_a[0], tx_a[1], tx_a[2]);
      end
      tests_run++;
      if (cyc_a[1] < rel) begin
        tests_failed++; $display("FAIL stall_release: 2nd at %0d before release %0d", cyc_a[1], rel);
      end
    end
  endtask

  task automatic test_count_256();
    int t;
    bit ex;
    clear_q();
    send(0, 8'h52, t); send(0, 8'h00, t); send(0, 8'h00, t);
    wait_inactive(0, 1200, ex);
    tests_run++;
    if (ex || tx_a.size() !== 256) begin
      tests_failed++; $display("FAIL count256: %0d bytes expired=%0b want 256", tx_a.size(), ex);
    end else begin
      tests_run++;
      if (tx_a[0] !== 8'hFF || tx_a[255] !== 8'h00) begin
        tests_failed++; $display("FAIL count256_ends: got %h %h want ff 00", tx_a[0], tx_a[255]);
      end
    end
  endtask

  task automatic test_wide();
    int t;
    bit ex;
    clear_q();
    send(1, 8'h52, t); send(1, 8'h01, t); send(1, 8'h23, t); send(1, 8'h02, t);
    @(posedge clk); #1;
    wait_inactive(1, 100, ex);
    tests_run++;
    if (ex || tx_b.size() !== 4) begin
      tests_failed++; $display("FAIL wide_count: %0d bytes expired=%0b want 4", tx_b.size(), ex);
    end else begin
      tests_run++;
      if ({tx_b[0], tx_b[1], tx_b[2], tx_b[3]} !== 32'h12231224) begin
        tests_failed++;
        $display("FAIL wide_bytes: got %h %h %h %h want 12 23 12 24", tx_b[0], tx_b[1], tx_b[2], tx_b[3]);
      end
      tests_run++;
      if (cyc_b[0] !== t + 3 || cyc_b[1] - cyc_b[0] !== 2 || cyc_b[2] - cyc_b[1] !== 4) begin
        tests_failed++;
        $display("FAIL wide_timing: first %0d (want %0d) gaps %0d %0d want 2 4",
                 cyc_b[0], t + 3, cyc_b[1] - cyc_b[0], cyc_b[2] - cyc_b[1]);
      end
    end
    clear_q();
    send(1, 8'h3F, t);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (tx_b.size() !== 1 || tx_b[0] !== 8'hAB) begin
      tests_failed++; $display("FAIL wide_query: %0d bytes first %h want 1 byte ab", tx_b.size(), tx_b[0]);
    end
  endtask

  task automatic test_dump_full();
    int t;
    bit ex;
    clear_q();
    send(2, 8'h44, t);
    wait_inactive(2, 200, ex);
    tests_run++;
    if (ex || tx_c.size() !== 16) begin
      tests_failed++; $display("FAIL dump_count: %0d bytes expired=%0b want 16", tx_c.size(), ex);
    end else begin
      tests_run++;
      if (tx_c[0] !== 8'h50 || tx_c[15] !== 8'h5F || cyc_c[0] !== t + 3 || addr_c !== 4'hF) begin
        tests_failed++;
        $display("FAIL dump_content: first %h last %h at %0d (want 50 5f at %0d) addr %h want f",
                 tx_c[0], tx_c[15], cyc_c[0], t + 3, addr_c);
      end
    end
  endtask

  task automatic test_abort_dump();
    int t;
    bit ex;
    clear_q();
    send(2, 8'h44, t);
    wait_txcount(2, 2, 50, ex);
    send(2, 8'h3F, t);
    wait_txcount(2, 5, 50, ex);
    send(2, 8'h1B, t);
    wait_inactive(2, 100, ex);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (ex || tx_c.size() < 5 || tx_c.size() > 6 || active_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_count: %0d bytes active=%0b expired=%0b want 5..6 inactive",
               tx_c.size(), active_c, ex);
    end else begin
      for (int i = 0; i < tx_c.size(); i++) begin
        tests_run++;
        if (tx_c[i] !== 8'h50 + 8'(i)) begin
          tests_failed++; $display("FAIL abort_byte%0d: got %h want %h", i, tx_c[i], 8'h50 + 8'(i));
        end
      end
    end
    clear_q();
    send(2, 8'h3F, t);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (tx_c.size() !== 1 || tx_c[0] !== 8'hA3 || cyc_c[0] !== t + 1) begin
      tests_failed++;
      $display("FAIL abort_query: %0d bytes first %h at %0d want a3 at %0d", tx_c.size(), tx_c[0], cyc_c[0], t + 1);
    end
  endtask

  task automatic test_timeout_nak();
    int t;
    clear_q();
    send(0, 8'h52, t); send(0, 8'h10, t);
    repeat (110) @(posedge clk);
    #1;
    tests_run++;
    if (tx_a.size() !== 0 || active_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_quiet: %0d bytes active=%0b want 0/0", tx_a.size(), active_a);
    end
    send(0, 8'h7A, t);
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (tx_a.size() !== 1 || tx_a[0] !== 8'h15 || cyc_a[0] !== t + 1) begin
      tests_failed++;
      $display("FAIL timeout_nak: %0d bytes first %h at %0d want 15 at %0d", tx_a.size(), tx_a[0], cyc_a[0], t + 1);
    end
  endtask

  task automatic test_no_consecutive();
    tests_run++;
    if (consec !== 0) begin
      tests_failed++; $display("FAIL no_consecutive: %0d back-to-back strobes want 0", consec);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_read();
    test_wrap_stall();
    test_count_256();
    test_wide();
    test_dump_full();
    test_abort_dump();
    test_timeout_nak();
    test_no_consecutive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
